mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one unified single-port, variable-latency memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store) of the 5-stage riscv pipeline.
//  Sequences each access with a req/ready handshake toward memory and returns per-requester grant and read data.
//  Drives stall flags so PC and the pipeline registers freeze while an access is outstanding.
//  Data port has priority; a starvation counter bounds consecutive data wins over a waiting fetch.
// PARAMETERS
//  STARVE_LIMIT  2  consecutive data grants allowed while if_req waits; 0 = strict data priority
//  AW            32 address width
//  DW            32 data width
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held with if_addr until if_gnt
//  if_addr    in   AW  fetch address
//  if_gnt     out  1   one-cycle pulse: fetch done, if_rdata valid
//  if_rdata   out  DW  fetched instruction, held until next fetch completes
//  if_stall   out  1   if_req & ~if_gnt
//  d_req      in   1   data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_addr     in   AW  data address
//  d_wdata    in   DW  store data
//  d_gnt      out  1   one-cycle pulse: data access done
//  d_rdata    out  DW  load data, held until next load completes
//  d_stall    out  1   d_req & ~d_gnt
//  mem_req    out  1   memory access active
//  mem_we     out  1   write strobe, valid with mem_req
//  mem_addr   out  AW  registered address, stable while mem_req
//  mem_wdata  out  DW  registered write data, stable while mem_req
//  mem_rdata  in   DW  read data, valid when mem_ready
//  mem_ready  in   1   access complete this cycle
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, starve_cnt=0, all registered outputs 0 incl. rdata regs.
//  States: IDLE, BUSY_I, BUSY_D.
//  IDLE: mem_req=0. Winner chosen on the clock edge:
//    d_req & (~if_req | STARVE_LIMIT==0 | starve_cnt<STARVE_LIMIT) -> BUSY_D
//    else if_req -> BUSY_I; neither -> stay IDLE.
//   Winner's addr/we/wdata are latched into mem_* on that edge (fetch: mem_we=0, mem_wdata=0).
//  BUSY_x: mem_req=1; mem_addr/we/wdata constant. On edge with mem_ready=1:
//   load/fetch: capture mem_rdata into x_rdata; store: d_rdata unchanged.
//   Pulse x_gnt high for exactly the following cycle; mem_req=0 and state=IDLE.
//  Latency: req seen at edge k -> mem_req high cycle k+1; mem_ready in cycle k+1+n -> gnt in cycle k+2+n.
//   Minimum 2 cycles/access. The gnt cycle is always IDLE, so the next grant is decided on the gnt edge.
//   A requester whose gnt has just pulsed must have updated its req by that edge.
//  Starvation: on a data grant while if_req=1, starve_cnt++ (saturates at STARVE_LIMIT).
//   Cleared on any fetch grant, and on any IDLE edge with if_req=0.
//  mem_ready while IDLE: ignored. Requester drop of req mid-BUSY: access still completes, gnt still pulses.
//  Simultaneous if_req/d_req in IDLE: resolved by the priority rule above. Never both gnts in one cycle.
//  Reset mid-BUSY: abort immediately; mem_req falls asynchronously; no gnt is issued after reset release.
//  x_stall is combinational from x_req and x_gnt.
// TESTING
//  T1 reset low with random inputs -> every output 0; release with no req -> mem_req stays 0.
//  T2 if_req, if_addr=0x10, mem_ready 3 cycles after mem_req, mem_rdata=0x00500093
//     -> mem_req high exactly 3 cycles, mem_addr=0x10, if_gnt 1 cycle, if_rdata=0x00500093.
//  T3 if_req and d_req (load 0x20) in same cycle -> D access first, then I; d_gnt precedes if_gnt, never overlap.
//  T4 STARVE_LIMIT=2, d_req and if_req held high, mem_ready=1 -> grant order D,D,I,D,D,I.
//  T5 store d_we=1 d_addr=0x40 d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, d_gnt pulses, d_rdata unchanged.
//  T6 assert reset in 2nd cycle of BUSY_D -> mem_req drops same cycle; after release, state IDLE, no d_gnt.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port variable-latency memory between fetch and data ports; data wins, bounded by a starvation counter.
// Latency: req seen at edge k -> mem_req in k+1, gnt one cycle after mem_ready; requesters stall until their gnt.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          d_win, i_win;

  // mem_req decodes straight from state so it drops the moment reset asserts.
  assign mem_req  = (state != IDLE);
  assign if_stall = if_req & ~if_gnt;
  assign d_stall  = d_req & ~d_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    d_win      = 1'b0;
    i_win      = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || STARVE_LIMIT == 0 || int'(starve_cnt) < STARVE_LIMIT)) begin
          d_win     = 1'b1;
          state_nxt = BUSY_D;
          if (if_req && int'(starve_cnt) < STARVE_LIMIT)
            starve_nxt = starve_cnt + 1'b1;
        end else if (if_req) begin
          i_win      = 1'b1;
          state_nxt  = BUSY_I;
          starve_nxt = '0;
        end
        if (!if_req)
          starve_nxt = '0;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt <= (state == BUSY_I) && mem_ready;
      d_gnt  <= (state == BUSY_D) && mem_ready;
      if (d_win) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (i_win) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      if (state == BUSY_I && mem_ready)
        if_rdata <= mem_rdata;
      // Stores leave the previous load data visible.
      if (state == BUSY_D && mem_ready && !mem_we)
        d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch latency, priority, starvation, store, reset abort.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int   n_chk = 0;
  int   n_err = 0;
  int   lat = 1;
  int   busy_cnt;
  logic ready_force = 1'b0;
  int   if_gnt_cnt, d_gnt_cnt, req_cyc, overlap;
  bit   order[$];

  mem_port_arbiter #(.STARVE_LIMIT(2), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0050_0093;
      32'h20:  return 32'h1111_2222;
      32'h30:  return 32'h3333_4444;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory answers in the lat-th cycle of each access.
  always @(posedge clk or negedge reset) begin
    if (!reset)        busy_cnt <= 0;
    else if (!mem_req) busy_cnt <= 0;
    else               busy_cnt <= busy_cnt + 1;
  end
  assign mem_ready = ready_force | (mem_req && busy_cnt == lat - 1);
  assign mem_rdata = mem_model(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    if_gnt_cnt = 0; d_gnt_cnt = 0; req_cyc = 0; overlap = 0;
    order.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    if (if_gnt && d_gnt) overlap++;
    if (d_gnt) begin d_gnt_cnt++; order.push_back(1'b1); end
    if (if_gnt) begin if_gnt_cnt++; order.push_back(1'b0); end
    if (mem_req) req_cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          patt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int          n;
    logic        got;
    logic [31:0] a_seen, wd_seen;
    logic        we_seen;

    // T1: reset with random inputs
    reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if_req = 1'($urandom); if_addr = $urandom; d_req = 1'($urandom); d_we = 1'($urandom);
      d_addr = $urandom; d_wdata = $urandom; ready_force = 1'($urandom);
      #1 chk("t1_mem_req", {31'b0, mem_req}, 32'h0);
    end
    chk("t1_if_gnt", {31'b0, if_gnt}, 32'h0);
    chk("t1_d_gnt", {31'b0, d_gnt}, 32'h0);
    chk("t1_if_rdata", if_rdata, 32'h0);
    chk("t1_d_rdata", d_rdata, 32'h0);
    chk("t1_mem_we", {31'b0, mem_we}, 32'h0);
    chk("t1_mem_addr", mem_addr, 32'h0);
    chk("t1_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; ready_force = 0;
    reset = 1'b1;
    clr();
    repeat (4) cyc();
    chk("t1_idle_after_release", req_cyc, 0);

    // T2: single fetch, memory answers in 3rd cycle
    clr(); lat = 3; if_req = 1; if_addr = 32'h10;
    chk("t2_if_stall", {31'b0, if_stall}, 32'h1);
    n = 0; got = 0; a_seen = 0; we_seen = 1'b1;
    while (!got && n < 20) begin
      cyc(); n++;
      if (mem_req) begin a_seen = mem_addr; we_seen = mem_we; end
      if (if_gnt) begin got = 1; if_req = 0; end
    end
    chk("t2_done", {31'b0, got}, 32'h1);
    chk("t2_latency", n, 4);
    chk("t2_req_cycles", req_cyc, 3);
    chk("t2_mem_addr", a_seen, 32'h10);
    chk("t2_mem_we", {31'b0, we_seen}, 32'h0);
    chk("t2_if_rdata", if_rdata, 32'h0050_0093);
    repeat (3) cyc();
    chk("t2_gnt_pulse", if_gnt_cnt, 1);

    // T3: simultaneous fetch and load; data first
    clr(); lat = 1;
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
    n = 0;
    while ((if_gnt_cnt == 0 || d_gnt_cnt == 0) && n < 30) begin
      cyc(); n++;
      if (d_gnt) d_req = 0;
      if (if_gnt) if_req = 0;
    end
    chk("t3_grants", order.size(), 2);
    chk("t3_first_is_d", {31'b0, order[0]}, 32'h1);
    chk("t3_second_is_i", {31'b0, order[1]}, 32'h0);
    chk("t3_no_overlap", overlap, 0);
    chk("t3_d_rdata", d_rdata, 32'h1111_2222);
    chk("t3_if_rdata", if_rdata, 32'h0050_0093);

    // T4: both held, starvation limit 2 -> D,D,I,D,D,I
    clr(); lat = 1;
    if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h30;
    n = 0;
    while (order.size() < 6 && n < 60) begin
      cyc(); n++;
      if (order.size() == 6) begin if_req = 0; d_req = 0; end
    end
    if_req = 0; d_req = 0;
    chk("t4_grants", order.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t4_order%0d", i), {31'b0, order[i]}, {31'b0, patt[i]});
    chk("t4_no_overlap", overlap, 0);
    chk("t4_d_rdata", d_rdata, 32'h3333_4444);

    // T5: store
    clr(); lat = 2;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    n = 0; got = 0; we_seen = 0; wd_seen = 0; a_seen = 0;
    while (!got && n < 20) begin
      cyc(); n++;
      if (mem_req) begin we_seen = mem_we; wd_seen = mem_wdata; a_seen = mem_addr; end
      if (d_gnt) begin got = 1; d_req = 0; d_we = 0; end
    end
    chk("t5_done", {31'b0, got}, 32'h1);
    chk("t5_mem_we", {31'b0, we_seen}, 32'h1);
    chk("t5_mem_wdata", wd_seen, 32'hDEAD_BEEF);
    chk("t5_mem_addr", a_seen, 32'h40);
    chk("t5_d_rdata_kept", d_rdata, 32'h3333_4444);
    repeat (3) cyc();
    chk("t5_gnt_pulse", d_gnt_cnt, 1);

    // T6: reset in 2nd cycle of a data access
    clr(); lat = 6;
    d_req = 1; d_we = 0; d_addr = 32'h20;
    cyc(); cyc();
    chk("t6_busy", {31'b0, mem_req}, 32'h1);
    reset = 1'b0;
    #1;
    chk("t6_req_drop", {31'b0, mem_req}, 32'h0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    d_req = 0;
    cyc();
    reset = 1'b1;
    clr();
    repeat (8) cyc();
    chk("t6_no_gnt", d_gnt_cnt, 0);
    chk("t6_idle", req_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
